// File: rtl/io_bus_arbiter_if.sv
// rtl/io_bus_arbiter_if.sv - master-side and io-side signal bundle for io_bus_arbiter.
// Lock inputs exist only when IO_ARB_LOCK_EN is defined.
interface io_bus_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_ack;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_ack;
    logic [DATA_W-1:0] m1_rdata;

    logic [ADDR_W-1:0] io_address;
    logic [DATA_W-1:0] io_din;
    logic              io_w_en;
    logic              io_r_en;
    logic [DATA_W-1:0] io_dout;

`ifdef IO_ARB_LOCK_EN
    logic              m0_lock;
    logic              m1_lock;
`endif

    modport slave (
`ifdef IO_ARB_LOCK_EN
        input  m0_lock, m1_lock,
`endif
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_ack, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_ack, m1_rdata,
        output io_address, io_din, io_w_en, io_r_en,
        input  io_dout
    );

    modport master (
`ifdef IO_ARB_LOCK_EN
        output m0_lock, m1_lock,
`endif
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_ack, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_ack, m1_rdata,
        input  io_address, io_din, io_w_en, io_r_en,
        output io_dout
    );
endinterface

// File: rtl/io_bus_arbiter.sv
// rtl/io_bus_arbiter.sv - round-robin two-master arbiter for the 8-bit io register bus.
// Optional IO_ARB_LOCK_EN adds m0_lock/m1_lock for back-to-back re-grant of the same master.
module io_bus_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input logic              clk,
    input logic              rst_n,
    io_bus_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              grant_q, grant_d;
    logic              last_grant_q, last_grant_d;
    logic              lock_hold_q, lock_hold_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    logic lock0, lock1;
    logic holder_req, pick;
    logic ack0, ack1;

`ifdef IO_ARB_LOCK_EN
    assign lock0 = bus.m0_lock;
    assign lock1 = bus.m1_lock;
`else
    assign lock0 = 1'b0;
    assign lock1 = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            lock_hold_q  <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            lock_hold_q  <= lock_hold_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    // A held lock beats round-robin only while its owner keeps requesting.
    always_comb begin
        holder_req = last_grant_q ? bus.m1_req : bus.m0_req;
        if (lock_hold_q && holder_req) begin
            pick = last_grant_q;
        end else if (bus.m0_req && bus.m1_req) begin
            pick = ~last_grant_q;
        end else begin
            pick = bus.m1_req;
        end

        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.m0_req || bus.m1_req) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        lock_hold_d  = lock_hold_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        unique case (state_q)
            IDLE: begin
                lock_hold_d = 1'b0;
                if (bus.m0_req || bus.m1_req) begin
                    grant_d = pick;
                    we_d    = pick ? bus.m1_we    : bus.m0_we;
                    addr_d  = pick ? bus.m1_addr  : bus.m0_addr;
                    wdata_d = pick ? bus.m1_wdata : bus.m0_wdata;
                end
            end
            RESP: begin
                last_grant_d = grant_q;
                lock_hold_d  = grant_q ? lock1 : lock0;
                if (!we_q) begin
                    if (grant_q) rdata1_d = bus.io_dout;
                    else         rdata0_d = bus.io_dout;
                end
            end
            default: ;
        endcase
    end

    assign ack0 = (state_q == RESP) && !grant_q;
    assign ack1 = (state_q == RESP) &&  grant_q;

    assign bus.io_address = addr_q;
    assign bus.io_din     = wdata_q;
    assign bus.io_w_en    = (state_q == ACCESS) &&  we_q;
    assign bus.io_r_en    = (state_q == ACCESS) && !we_q;
    assign bus.m0_ack     = ack0;
    assign bus.m1_ack     = ack1;

    // io_dout only becomes valid in the ack cycle, so it is forwarded then and held afterwards.
    assign bus.m0_rdata = (ack0 && !we_q) ? bus.io_dout : rdata0_q;
    assign bus.m1_rdata = (ack1 && !we_q) ? bus.io_dout : rdata1_q;
endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb/tb_io_bus_arbiter.sv - scoreboard bench for io_bus_arbiter with a registered io register model.
module tb_io_bus_arbiter;
    logic clk;
    logic rst_n;

    io_bus_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    io_bus_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int       m;
        bit       we;
        bit [7:0] addr;
        bit [7:0] data;
        bit       lat_chk;
        bit       gap_chk;
    } exp_t;

    typedef struct {
        bit       we;
        bit [7:0] addr;
        bit [7:0] wdata;
    } req_t;

    exp_t exp_s[$];
    exp_t exp_a[$];
    req_t mq0[$];
    req_t mq1[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int issue_cyc0 = 0;
    int issue_cyc1 = 0;
    int last_ack_cyc = 0;
    bit prev_strobe = 1'b0;

    logic [7:0] mem [256];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (bus.io_w_en) mem[bus.io_address] <= bus.io_din;
        if (bus.io_r_en) bus.io_dout <= mem[bus.io_address];
    end

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic expect_acc(input int m, input bit we, input bit [7:0] addr, input bit [7:0] data,
                              input bit lat, input bit gap);
        exp_t e;
        req_t r;
        e = '{m: m, we: we, addr: addr, data: data, lat_chk: lat, gap_chk: gap};
        exp_s.push_back(e);
        exp_a.push_back(e);
        r = '{we: we, addr: addr, wdata: data};
        if (m == 0) mq0.push_back(r);
        else        mq1.push_back(r);
    endtask

    // One negedge step; masters hold req until their ack and drop it in the ack cycle.
    task automatic tick();
        @(negedge clk);
        if (bus.m0_req && bus.m0_ack) begin
            void'(mq0.pop_front());
            if (mq0.size() == 0) bus.m0_req = 1'b0;
            else begin
                bus.m0_we = mq0[0].we; bus.m0_addr = mq0[0].addr; bus.m0_wdata = mq0[0].wdata;
                issue_cyc0 = cyc + 1;
            end
        end else if (!bus.m0_req && mq0.size() > 0) begin
            bus.m0_we = mq0[0].we; bus.m0_addr = mq0[0].addr; bus.m0_wdata = mq0[0].wdata;
            bus.m0_req = 1'b1;
            issue_cyc0 = cyc;
        end
        if (bus.m1_req && bus.m1_ack) begin
            void'(mq1.pop_front());
            if (mq1.size() == 0) bus.m1_req = 1'b0;
            else begin
                bus.m1_we = mq1[0].we; bus.m1_addr = mq1[0].addr; bus.m1_wdata = mq1[0].wdata;
                issue_cyc1 = cyc + 1;
            end
        end else if (!bus.m1_req && mq1.size() > 0) begin
            bus.m1_we = mq1[0].we; bus.m1_addr = mq1[0].addr; bus.m1_wdata = mq1[0].wdata;
            bus.m1_req = 1'b1;
            issue_cyc1 = cyc;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_a.size() > 0 || mq0.size() > 0 || mq1.size() > 0) && n < 200) begin
            tick();
            n++;
        end
        chk("drain_pending", exp_a.size(), 0);
        exp_a.delete();
        exp_s.delete();
        mq0.delete();
        mq1.delete();
        bus.m0_req = 1'b0;
        bus.m1_req = 1'b0;
        tick();
        tick();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (bus.io_w_en || bus.io_r_en) begin
                chk("strobe_exclusive", int'(bus.io_w_en && bus.io_r_en), 0);
                chk("strobe_width", int'(prev_strobe), 0);
                if (exp_s.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_strobe actual=addr %0h required=none", bus.io_address);
                end else begin
                    e = exp_s.pop_front();
                    chk("strobe_we", int'(bus.io_w_en), int'(e.we));
                    chk("strobe_addr", int'(bus.io_address), int'(e.addr));
                    if (e.we) chk("strobe_din", int'(bus.io_din), int'(e.data));
                end
            end
            prev_strobe = bus.io_w_en || bus.io_r_en;
            if (bus.m0_ack || bus.m1_ack) begin
                chk("ack_exclusive", int'(bus.m0_ack && bus.m1_ack), 0);
                if (exp_a.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_ack actual=m%0d required=none", bus.m1_ack ? 1 : 0);
                end else begin
                    e = exp_a.pop_front();
                    chk("ack_master", bus.m1_ack ? 1 : 0, e.m);
                    if (!e.we) chk("ack_rdata", int'(e.m == 1 ? bus.m1_rdata : bus.m0_rdata), int'(e.data));
                    if (e.lat_chk) chk("ack_latency", cyc - (e.m == 1 ? issue_cyc1 : issue_cyc0), 2);
                    if (e.gap_chk) chk("ack_gap", cyc - last_ack_cyc, 3);
                end
                last_ack_cyc = cyc;
            end
        end else begin
            prev_strobe = 1'b0;
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h08] = 8'h5A;
        bus.io_dout = 8'h00;
        bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = 8'h00; bus.m0_wdata = 8'h00;
        bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = 8'h00; bus.m1_wdata = 8'h00;
`ifdef IO_ARB_LOCK_EN
        bus.m0_lock = 1'b0;
        bus.m1_lock = 1'b0;
`endif
        rst_n = 1'b0;
        #1;
        chk("rst_io_w_en", int'(bus.io_w_en), 0);
        chk("rst_io_r_en", int'(bus.io_r_en), 0);
        chk("rst_io_address", int'(bus.io_address), 0);
        chk("rst_io_din", int'(bus.io_din), 0);
        chk("rst_m0_ack", int'(bus.m0_ack), 0);
        chk("rst_m1_ack", int'(bus.m1_ack), 0);
        chk("rst_m0_rdata", int'(bus.m0_rdata), 0);
        chk("rst_m1_rdata", int'(bus.m1_rdata), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // single m0 write, then single m1 read
        expect_acc(0, 1'b1, 8'h05, 8'h02, 1'b1, 1'b0);
        drain();
        expect_acc(1, 1'b0, 8'h08, 8'h5A, 1'b1, 1'b0);
        drain();
        chk("m0_rdata_untouched", int'(bus.m0_rdata), 0);
        chk("m1_rdata_held", int'(bus.m1_rdata), 8'h5A);

        // m0 pulses req for one cycle while m1 owns the bus
        expect_acc(1, 1'b0, 8'h05, 8'h02, 1'b0, 1'b0);
        for (int n = 0; n < 20 && !bus.io_r_en; n++) tick();
        chk("t6_m1_strobe_seen", int'(bus.io_r_en), 1);
        bus.m0_we = 1'b1; bus.m0_addr = 8'h30; bus.m0_wdata = 8'hEE;
        bus.m0_req = 1'b1;
        tick();
        bus.m0_req = 1'b0;
        drain();
        chk("t6_no_m0_write", int'(mem[8'h30]), 0);

        // reset while a write strobe is on the bus
        bus.m0_we = 1'b1; bus.m0_addr = 8'h20; bus.m0_wdata = 8'h99;
        bus.m0_req = 1'b1;
        @(posedge clk);
        #2;
        chk("t4_strobe_up", int'(bus.io_w_en), 1);
        rst_n = 1'b0;
        #1;
        chk("t4_w_en_drop", int'(bus.io_w_en), 0);
        chk("t4_r_en_drop", int'(bus.io_r_en), 0);
        bus.m0_req = 1'b0;
        tick();
        chk("t4_no_ack0", int'(bus.m0_ack), 0);
        chk("t4_no_ack1", int'(bus.m1_ack), 0);
        tick();

        // both masters contend for six accesses after reset
        expect_acc(0, 1'b1, 8'h10, 8'hA1, 1'b0, 1'b0);
        expect_acc(1, 1'b0, 8'h08, 8'h5A, 1'b0, 1'b1);
        expect_acc(0, 1'b0, 8'h10, 8'hA1, 1'b0, 1'b1);
        expect_acc(1, 1'b1, 8'h12, 8'hC3, 1'b0, 1'b1);
        expect_acc(0, 1'b1, 8'h11, 8'hB2, 1'b0, 1'b1);
        expect_acc(1, 1'b0, 8'h12, 8'hC3, 1'b0, 1'b1);
        rst_n = 1'b1;
        drain();

        // m1 two-register sequence racing an m0 write
        expect_acc(0, 1'b1, 8'h06, 8'h11, 1'b0, 1'b0);
        drain();
`ifdef IO_ARB_LOCK_EN
        bus.m1_lock = 1'b1;
        expect_acc(1, 1'b1, 8'h03, 8'h34, 1'b0, 1'b0);
        expect_acc(1, 1'b1, 8'h04, 8'h12, 1'b0, 1'b1);
        expect_acc(0, 1'b1, 8'h07, 8'h77, 1'b0, 1'b1);
`else
        expect_acc(1, 1'b1, 8'h03, 8'h34, 1'b0, 1'b0);
        expect_acc(0, 1'b1, 8'h07, 8'h77, 1'b0, 1'b1);
        expect_acc(1, 1'b1, 8'h04, 8'h12, 1'b0, 1'b1);
`endif
        drain();
`ifdef IO_ARB_LOCK_EN
        bus.m1_lock = 1'b0;
`endif
        expect_acc(0, 1'b0, 8'h03, 8'h34, 1'b0, 1'b0);
        expect_acc(0, 1'b0, 8'h04, 8'h12, 1'b0, 1'b1);
        expect_acc(0, 1'b0, 8'h07, 8'h77, 1'b0, 1'b0);
        drain();
        chk("final_m0_rdata", int'(bus.m0_rdata), 8'h77);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
